// File: rtl/bist_pkg.sv
// bist_pkg -- shared types and constants for the BIST controller
// Rev 1.0
`default_nettype none

package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int          SIG_W        = 16;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] TAP_MASK     = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bist_lfsr.sv
// bist_lfsr -- 16-bit Fibonacci shift register with load, enable and parallel XOR input
// Rev 1.0
`default_nettype none

module bist_lfsr
  import bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] load_val,
  input  logic             en,
  input  logic [SIG_W-1:0] xor_in,
  output logic [SIG_W-1:0] q,
  output logic [SIG_W-1:0] d
);

  logic fb;

  assign fb = ^(q & TAP_MASK);

  // d is the value q takes at the next edge; exposed so callers can act on it.
  always_comb begin
    d = q;
    if (load) begin
      d = load_val;
    end else if (en) begin
      d = {q[SIG_W-2:0], fb} ^ xor_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bist_ctrl.sv
// bist_ctrl -- BIST sequencer: LFSR patterns into the CUT, MISR compaction of its responses
// Rev 1.0
`default_nettype none

module bist_ctrl
  import bist_pkg::*;
#(
  parameter int          PI_W       = 4,
  parameter int          PO_W       = 2,
  parameter int          N_PATTERNS = 255,
  parameter int          CUT_LAT    = 2,
  parameter logic [15:0] SEED       = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PI_W-1:0] cut_pi,
  input  logic [PO_W-1:0] cut_po,
  input  logic [15:0]     golden,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature
);

  localparam int CNT_MAX = (N_PATTERNS > CUT_LAT) ? N_PATTERNS : CUT_LAT;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CUT_LAT-1:0] vld;
  logic               start_run;
  logic               in_run;
  logic               capture;
  logic [SIG_W-1:0]   lfsr_q;
  logic [SIG_W-1:0]   lfsr_d;
  logic [SIG_W-1:0]   misr_q;
  logic [SIG_W-1:0]   misr_d;
  logic [SIG_W-1:0]   po_ext;
  logic               unused_lfsr;

  assign start_run = start && ((state == IDLE) || (state == DONE));
  assign in_run    = (state == RUN);
  assign capture   = vld[CUT_LAT-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(N_PATTERNS - 1)) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (cnt == CNT_W'(CUT_LAT - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One bit per RUN cycle, delayed by the CUT latency to mark response capture cycles.
  generate
    if (CUT_LAT == 1) begin : g_vld_one
      always_ff @(posedge clk) begin
        if (rst) begin
          vld <= '0;
        end else begin
          vld <= in_run;
        end
      end
    end else begin : g_vld_multi
      always_ff @(posedge clk) begin
        if (rst) begin
          vld <= '0;
        end else begin
          vld <= {vld[CUT_LAT-2:0], in_run};
        end
      end
    end
  endgenerate

  always_comb begin
    po_ext            = '0;
    po_ext[PO_W-1:0]  = cut_po;
  end

  bist_lfsr #(
    .RESET_VAL (SEED)
  ) u_pattern (
    .clk      (clk),
    .rst      (rst),
    .load     (start_run),
    .load_val (SEED),
    .en       (in_run),
    .xor_in   ('0),
    .q        (lfsr_q),
    .d        (lfsr_d)
  );

  bist_lfsr #(
    .RESET_VAL ('0)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_run),
    .load_val ('0),
    .en       (capture),
    .xor_in   (po_ext),
    .q        (misr_q),
    .d        (misr_d)
  );

  assign unused_lfsr = ^{lfsr_q, lfsr_d};

  // The final MISR update lands on the same edge that enters DONE, so compare its next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass <= 1'b0;
    end else if (start_run) begin
      pass <= 1'b0;
    end else if ((state == FLUSH) && (state_nxt == DONE)) begin
      pass <= (misr_d == golden);
    end
  end

  always_comb begin
    cut_pi = '0;
    if (state == RUN) begin
      cut_pi = lfsr_q[PI_W-1:0];
    end
  end

  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);
  assign signature = misr_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl -- randomized self-checking bench for bist_ctrl against a behavioural model
// Rev 1.0
`default_nettype none

module tb_bist_ctrl;

  localparam int          LAT    = 2;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        drv_start;
  logic [1:0]  drv_po;
  logic [15:0] drv_golden;

  logic        start0, start1;
  logic [3:0]  pi0, pi1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] sig0, sig1;

  logic [3:0]  obs_pi;
  logic        obs_busy, obs_done, obs_pass;
  logic [15:0] obs_sig;

  int vectors;
  int miscompares;

  assign start0   = drv_start & ~sel;
  assign start1   = drv_start & sel;
  assign obs_pi   = sel ? pi1   : pi0;
  assign obs_busy = sel ? busy1 : busy0;
  assign obs_done = sel ? done1 : done0;
  assign obs_pass = sel ? pass1 : pass0;
  assign obs_sig  = sel ? sig1  : sig0;

  bist_ctrl #(
    .PI_W(4), .PO_W(2), .N_PATTERNS(255), .CUT_LAT(LAT), .SEED(SEED_V)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cut_pi(pi0), .cut_po(drv_po),
    .golden(drv_golden), .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
  );

  bist_ctrl #(
    .PI_W(4), .PO_W(2), .N_PATTERNS(1), .CUT_LAT(LAT), .SEED(SEED_V)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cut_pi(pi1), .cut_po(drv_po),
    .golden(drv_golden), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] p);
    return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [1:0] po);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {14'b0, po};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, obs_busy, 0);
    chk({tag, "_done"}, obs_done, 0);
    chk({tag, "_pass"}, obs_pass, 0);
    chk({tag, "_pi"},   obs_pi,   0);
    chk({tag, "_sig"},  obs_sig,  0);
  endtask

  // mode: 0 = all-zero responses, 1 = random, 2 = 2'b01 only in the first capture cycle.
  // gsel: 0 = golden equals model signature, 1 = one bit off, 2 = explicit gval.
  task automatic run(input bit s, input int mode, input int gsel, input logic [15:0] gval,
                     input bit poke, input int abort_at);
    int          n, total;
    logic [15:0] pats [0:255];
    logic [1:0]  po [0:299];
    logic [15:0] p, m, exp_sig, gold;
    logic [3:0]  exp_pi;
    bit          exp_pass;
    n     = s ? 1 : 255;
    total = n + LAT + 1;
    p     = SEED_V;
    for (int i = 0; i < n; i++) begin
      pats[i] = p;
      p       = lfsr_step(p);
    end
    for (int k = 0; k < 300; k++) begin
      case (mode)
        0:       po[k] = 2'b00;
        2:       po[k] = (k == LAT + 1) ? 2'b01 : 2'b00;
        default: po[k] = 2'($urandom_range(0, 3));
      endcase
    end
    // Responses to patterns 1..n arrive in cycles LAT+1 .. LAT+n after the start edge.
    exp_sig = '0;
    for (int k = LAT + 1; k <= LAT + n; k++) exp_sig = misr_step(exp_sig, po[k]);
    case (gsel)
      0:       gold = exp_sig;
      1:       gold = exp_sig ^ (16'h1 << $urandom_range(0, 15));
      default: gold = gval;
    endcase
    exp_pass = (gold == exp_sig);

    @(negedge clk);
    drv_golden = gold;
    drv_po     = 2'b00;
    drv_start  = 1'b1;
    m          = '0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      drv_start = poke && (k == 10 || k == n + 1 || k == n + LAT);
      drv_po    = po[k];
      exp_pi    = 4'h0;
      if (k <= n) exp_pi = pats[k-1][3:0];
      chk("busy",      obs_busy, (k <= n + LAT) ? 1 : 0);
      chk("done",      obs_done, (k == total) ? 1 : 0);
      chk("cut_pi",    obs_pi,   exp_pi);
      chk("signature", obs_sig,  m);
      chk("pass",      obs_pass, (k == total) ? exp_pass : 1'b0);
      if (k == abort_at) begin
        rst       = 1'b1;
        drv_start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        drv_start = 1'b0;
        chk_idle("abort");
        @(negedge clk);
        chk("abort_stay_idle", obs_busy, 0);
        return;
      end
      if (k > LAT && k <= LAT + n) m = misr_step(m, po[k]);
    end
    @(negedge clk);
    drv_start = 1'b0;
    drv_po    = 2'($urandom_range(0, 3));
    chk("done_held", obs_done, 1);
    chk("sig_held",  obs_sig,  exp_sig);
    chk("pass_held", obs_pass, exp_pass);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    sel         = 1'b0;
    drv_start   = 1'b1;
    drv_po      = 2'b00;
    drv_golden  = 16'h0000;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    drv_start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    run(1'b0, 0, 2, 16'h0000, 1'b0, -1);   // zero responses, golden 0 -> pass
    run(1'b0, 0, 2, 16'h0001, 1'b0, -1);   // zero responses, golden 1 -> fail flag
    run(1'b0, 1, 0, 16'h0000, 1'b0, -1);
    run(1'b0, 1, 1, 16'h0000, 1'b0, -1);
    run(1'b0, 1, 0, 16'h0000, 1'b1, -1);   // start pokes in RUN and FLUSH
    run(1'b0, 1, 0, 16'h0000, 1'b0, 10);   // reset in RUN cycle 10, with start held
    run(1'b0, 1, 0, 16'h0000, 1'b0, -1);   // restart from IDLE

    @(negedge clk);
    sel = 1'b1;
    run(1'b1, 2, 2, 16'h0001, 1'b0, -1);   // single pattern, single capture -> 16'h0001
    run(1'b1, 1, 0, 16'h0000, 1'b1, -1);
    run(1'b1, 1, 1, 16'h0000, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
